// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, ALUOp classes and the EX-stage control bundle.
package pipeline_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 3;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_RTYPE = 3'd2,
    ALUOP_AND   = 3'd3,
    ALUOP_OR    = 3'd4,
    ALUOP_SLT   = 3'd5
  } aluop_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detection_unit.sv
// Combinational load-use detection; produces the stall and the PC / IF-ID write enables.
module hazard_detection_unit #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      mem_read_ex_i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_ex_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs_id_i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_id_i,
  input  logic                      uses_rt_id_i,
  input  logic                      flush_id_i,
  input  logic                      hold_i,
  output logic                      load_use_o,
  output logic                      stall_o,
  output logic                      pc_write_o,
  output logic                      if_id_write_o
);

  logic hazard_stall;

  assign load_use_o = mem_read_ex_i && (rt_ex_i != '0) &&
                      ((rt_ex_i == rs_id_i) || (uses_rt_id_i && (rt_ex_i == rt_id_i)));

  // A taken branch squashes the dependent instruction, so it must not freeze the PC.
  assign hazard_stall  = load_use_o && !flush_id_i;
  assign stall_o       = hazard_stall && !hold_i;
  assign pc_write_o    = !hold_i && !hazard_stall;
  assign if_id_write_o = !hold_i && !hazard_stall;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / flush bubble insertion and saturating bubble counters.
module id_ex_hazard_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned ALUOP_WIDTH    = ALUOP_W,
  parameter int unsigned CNT_WIDTH      = CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      flush_ID,
  input  logic                      clear_counts,
  input  logic [REG_ADDR_WIDTH-1:0] rs_ID,
  input  logic [REG_ADDR_WIDTH-1:0] rt_ID,
  input  logic [REG_ADDR_WIDTH-1:0] rd_ID,
  input  logic                      uses_rt_ID,
  input  logic [DATA_WIDTH-1:0]     read_data1_ID,
  input  logic [DATA_WIDTH-1:0]     read_data2_ID,
  input  logic [DATA_WIDTH-1:0]     imm_ID,
  input  logic                      RegWrite_ID,
  input  logic                      MemtoReg_ID,
  input  logic                      MemRead_ID,
  input  logic                      MemWrite_ID,
  input  logic                      ALUSrc_ID,
  input  logic                      RegDst_ID,
  input  logic [ALUOP_WIDTH-1:0]    ALUOp_ID,
  output logic [REG_ADDR_WIDTH-1:0] rs_EX,
  output logic [REG_ADDR_WIDTH-1:0] rt_EX,
  output logic [REG_ADDR_WIDTH-1:0] rd_EX,
  output logic [DATA_WIDTH-1:0]     read_data1_EX,
  output logic [DATA_WIDTH-1:0]     read_data2_EX,
  output logic [DATA_WIDTH-1:0]     imm_EX,
  output logic                      RegWrite_EX,
  output logic                      MemtoReg_EX,
  output logic                      MemRead_EX,
  output logic                      MemWrite_EX,
  output logic                      ALUSrc_EX,
  output logic                      RegDst_EX,
  output logic [ALUOP_WIDTH-1:0]    ALUOp_EX,
  output logic                      stall,
  output logic                      PCWrite,
  output logic                      IF_ID_Write,
  output logic [CNT_WIDTH-1:0]      load_use_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  ex_ctrl_t                  ctrl_id, ctrl_q, ctrl_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
  logic [CNT_WIDTH-1:0]      lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;
  logic                      load_use;

  assign ctrl_id = '{reg_write:  RegWrite_ID,
                     mem_to_reg: MemtoReg_ID,
                     mem_read:   MemRead_ID,
                     mem_write:  MemWrite_ID,
                     alu_src:    ALUSrc_ID,
                     reg_dst:    RegDst_ID,
                     alu_op:     ALUOp_ID};

  hazard_detection_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hdu (
    .mem_read_ex_i (ctrl_q.mem_read),
    .rt_ex_i       (rt_q),
    .rs_id_i       (rs_ID),
    .rt_id_i       (rt_ID),
    .uses_rt_id_i  (uses_rt_ID),
    .flush_id_i    (flush_ID),
    .hold_i        (hold),
    .load_use_o    (load_use),
    .stall_o       (stall),
    .pc_write_o    (PCWrite),
    .if_id_write_o (IF_ID_Write)
  );

  // Next state: hold freezes everything, a bubble zeroes control and specifiers but keeps data.
  always_comb begin
    ctrl_d   = ctrl_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    imm_d    = imm_q;
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (!hold) begin
      if (flush_ID || load_use) begin
        ctrl_d = EX_CTRL_BUBBLE;
        rs_d   = '0;
        rt_d   = '0;
        rd_d   = '0;
      end else begin
        ctrl_d  = ctrl_id;
        rs_d    = rs_ID;
        rt_d    = rt_ID;
        rd_d    = rd_ID;
        data1_d = read_data1_ID;
        data2_d = read_data2_ID;
        imm_d   = imm_ID;
      end
      if (clear_counts) begin
        lu_cnt_d = '0;
        fl_cnt_d = '0;
      end else begin
        if (flush_ID && (fl_cnt_q != CNT_MAX)) fl_cnt_d = fl_cnt_q + CNT_WIDTH'(1);
        if (load_use && !flush_ID && (lu_cnt_q != CNT_MAX)) lu_cnt_d = lu_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= EX_CTRL_BUBBLE;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      imm_q    <= '0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      imm_q    <= imm_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign rs_EX          = rs_q;
  assign rt_EX          = rt_q;
  assign rd_EX          = rd_q;
  assign read_data1_EX  = data1_q;
  assign read_data2_EX  = data2_q;
  assign imm_EX         = imm_q;
  assign RegWrite_EX    = ctrl_q.reg_write;
  assign MemtoReg_EX    = ctrl_q.mem_to_reg;
  assign MemRead_EX     = ctrl_q.mem_read;
  assign MemWrite_EX    = ctrl_q.mem_write;
  assign ALUSrc_EX      = ctrl_q.alu_src;
  assign RegDst_EX      = ctrl_q.reg_dst;
  assign ALUOp_EX       = ctrl_q.alu_op;
  assign load_use_count = lu_cnt_q;
  assign flush_count    = fl_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage: directed hazard scenarios then constrained-random traffic.
module tb_id_ex_hazard_stage;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic        rw, m2r, mr, mw, as, rdst;
    logic [2:0]  alu;
  } stage_t;

  typedef struct {
    stage_t ex;
    int     lu, fl, lus, fls;
  } exp_reg_t;

  typedef struct {
    logic stall, pcw, ifw;
  } exp_comb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, hold, flush_ID, clear_counts, uses_rt_ID;
  logic [4:0]  rs_ID, rt_ID, rd_ID;
  logic [31:0] read_data1_ID, read_data2_ID, imm_ID;
  logic        RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, RegDst_ID;
  logic [2:0]  ALUOp_ID;

  logic [4:0]  rs_EX, rt_EX, rd_EX, s_rs_EX, s_rt_EX, s_rd_EX;
  logic [31:0] read_data1_EX, read_data2_EX, imm_EX, s_read_data1_EX, s_read_data2_EX, s_imm_EX;
  logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, RegDst_EX;
  logic        s_RegWrite_EX, s_MemtoReg_EX, s_MemRead_EX, s_MemWrite_EX, s_ALUSrc_EX, s_RegDst_EX;
  logic [2:0]  ALUOp_EX, s_ALUOp_EX;
  logic        stall, PCWrite, IF_ID_Write, s_stall, s_PCWrite, s_IF_ID_Write;
  logic [15:0] load_use_count, flush_count;
  logic [1:0]  s_load_use_count, s_flush_count;

  stage_t dut_stage, sat_stage;
  assign dut_stage = {rs_EX, rt_EX, rd_EX, read_data1_EX, read_data2_EX, imm_EX, RegWrite_EX,
                      MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, RegDst_EX, ALUOp_EX};
  assign sat_stage = {s_rs_EX, s_rt_EX, s_rd_EX, s_read_data1_EX, s_read_data2_EX, s_imm_EX,
                      s_RegWrite_EX, s_MemtoReg_EX, s_MemRead_EX, s_MemWrite_EX, s_ALUSrc_EX,
                      s_RegDst_EX, s_ALUOp_EX};

  id_ex_hazard_stage dut (
    .clk(clk), .reset(reset), .hold(hold), .flush_ID(flush_ID), .clear_counts(clear_counts),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID), .uses_rt_ID(uses_rt_ID),
    .read_data1_ID(read_data1_ID), .read_data2_ID(read_data2_ID), .imm_ID(imm_ID),
    .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID), .ALUOp_ID(ALUOp_ID),
    .rs_EX(rs_EX), .rt_EX(rt_EX), .rd_EX(rd_EX),
    .read_data1_EX(read_data1_EX), .read_data2_EX(read_data2_EX), .imm_EX(imm_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .ALUSrc_EX(ALUSrc_EX), .RegDst_EX(RegDst_EX), .ALUOp_EX(ALUOp_EX),
    .stall(stall), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .load_use_count(load_use_count), .flush_count(flush_count)
  );

  id_ex_hazard_stage #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .hold(hold), .flush_ID(flush_ID), .clear_counts(clear_counts),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID), .uses_rt_ID(uses_rt_ID),
    .read_data1_ID(read_data1_ID), .read_data2_ID(read_data2_ID), .imm_ID(imm_ID),
    .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID), .ALUOp_ID(ALUOp_ID),
    .rs_EX(s_rs_EX), .rt_EX(s_rt_EX), .rd_EX(s_rd_EX),
    .read_data1_EX(s_read_data1_EX), .read_data2_EX(s_read_data2_EX), .imm_EX(s_imm_EX),
    .RegWrite_EX(s_RegWrite_EX), .MemtoReg_EX(s_MemtoReg_EX), .MemRead_EX(s_MemRead_EX),
    .MemWrite_EX(s_MemWrite_EX), .ALUSrc_EX(s_ALUSrc_EX), .RegDst_EX(s_RegDst_EX),
    .ALUOp_EX(s_ALUOp_EX), .stall(s_stall), .PCWrite(s_PCWrite), .IF_ID_Write(s_IF_ID_Write),
    .load_use_count(s_load_use_count), .flush_count(s_flush_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_reg_t  q_reg[$];
  exp_comb_t q_comb[$];

  // Reference state: the instruction sitting in EX plus the bubble tallies.
  stage_t m;
  int     m_lu, m_fl, m_lus, m_fls;
  bit     m_known  = 1'b0;
  bit     last_ifw = 1'b1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int w);
    int top = (1 << w) - 1;
    return (v >= top) ? top : v + 1;
  endfunction

  function automatic stage_t mk(input logic [4:0] rs, rt, rd, input logic mr, input logic [31:0] d1);
    stage_t s = '0;
    s.rs = rs; s.rt = rt; s.rd = rd;
    s.d1 = d1; s.d2 = ~d1; s.imm = d1 ^ 32'h0000_ff00;
    s.rw = 1'b1; s.mr = mr; s.m2r = mr; s.as = mr; s.rdst = ~mr;
    s.alu = mr ? 3'd0 : 3'd2;
    return s;
  endfunction

  // Drive one ID-stage cycle, predict outputs, and hand the predictions to the monitors.
  task automatic step(input stage_t s, input bit u, input bit h, input bit f, input bit c, input bit r);
    bit lu;
    exp_comb_t ec;
    exp_reg_t  er;
    @(negedge clk);
    reset = r; hold = h; flush_ID = f; clear_counts = c; uses_rt_ID = u;
    rs_ID = s.rs; rt_ID = s.rt; rd_ID = s.rd;
    read_data1_ID = s.d1; read_data2_ID = s.d2; imm_ID = s.imm;
    RegWrite_ID = s.rw; MemtoReg_ID = s.m2r; MemRead_ID = s.mr; MemWrite_ID = s.mw;
    ALUSrc_ID = s.as; RegDst_ID = s.rdst; ALUOp_ID = s.alu;
    #1;
    lu = m.mr && (m.rt != 0) && ((m.rt == s.rs) || (u && (m.rt == s.rt)));
    ec.stall = lu && !f && !h;
    ec.pcw   = !h && !(lu && !f);
    ec.ifw   = ec.pcw;
    if (m_known) q_comb.push_back(ec);
    last_ifw = m_known ? ec.ifw : 1'b1;
    if (r) begin
      m = '0; m_lu = 0; m_fl = 0; m_lus = 0; m_fls = 0; m_known = 1'b1;
    end else if (!h) begin
      if (f || lu) begin
        m.rs = 0; m.rt = 0; m.rd = 0;
        m.rw = 0; m.m2r = 0; m.mr = 0; m.mw = 0; m.as = 0; m.rdst = 0; m.alu = 0;
      end else begin
        m = s;
      end
      if (c) begin
        m_lu = 0; m_fl = 0; m_lus = 0; m_fls = 0;
      end else begin
        if (f) begin
          m_fl = sat_inc(m_fl, 16); m_fls = sat_inc(m_fls, 2);
        end
        if (lu && !f) begin
          m_lu = sat_inc(m_lu, 16); m_lus = sat_inc(m_lus, 2);
        end
      end
    end
    if (m_known) begin
      er.ex = m; er.lu = m_lu; er.fl = m_fl; er.lus = m_lus; er.fls = m_fls;
      q_reg.push_back(er);
    end
  endtask

  // Registered-output monitor.
  initial forever begin
    exp_reg_t e;
    @(posedge clk);
    #1;
    if (q_reg.size() != 0) begin
      e = q_reg.pop_front();
      chk("ex_stage", 128'(dut_stage), 128'(e.ex));
      chk("load_use_count", 128'(load_use_count), 128'(e.lu));
      chk("flush_count", 128'(flush_count), 128'(e.fl));
      chk("sat_ex_stage", 128'(sat_stage), 128'(e.ex));
      chk("sat_load_use_count", 128'(s_load_use_count), 128'(e.lus));
      chk("sat_flush_count", 128'(s_flush_count), 128'(e.fls));
    end
  end

  // Combinational-output monitor, sampled mid-cycle while the ID inputs are stable.
  initial forever begin
    exp_comb_t e;
    @(negedge clk);
    #2;
    if (q_comb.size() != 0) begin
      e = q_comb.pop_front();
      chk("stall", 128'(stall), 128'(e.stall));
      chk("PCWrite", 128'(PCWrite), 128'(e.pcw));
      chk("IF_ID_Write", 128'(IF_ID_Write), 128'(e.ifw));
      chk("sat_stall", 128'(s_stall), 128'(e.stall));
    end
  end

  initial begin
    stage_t lw8, use8, cur;
    bit u;
    m = '0; m_lu = 0; m_fl = 0; m_lus = 0; m_fls = 0;
    lw8  = mk(5'd2, 5'd8, 5'd0, 1'b1, 32'h0000_0080);
    use8 = mk(5'd8, 5'd6, 5'd7, 1'b0, 32'h0000_0030);

    step(mk(5'd1, 5'd2, 5'd3, 1'b1, 32'hA5A5_5A5A), 1, 0, 0, 0, 1);
    step(mk(5'd3, 5'd4, 5'd5, 1'b0, 32'h0000_0011), 1, 0, 0, 0, 0);
    step(lw8, 0, 0, 0, 0, 0);
    step(use8, 1, 0, 0, 0, 0);
    step(use8, 1, 0, 0, 0, 0);
    step(mk(5'd2, 5'd0, 5'd0, 1'b1, 32'h0000_0040), 0, 0, 0, 0, 0);
    step(mk(5'd0, 5'd0, 5'd7, 1'b0, 32'h0000_0050), 1, 0, 0, 0, 0);
    step(mk(5'd2, 5'd9, 5'd0, 1'b1, 32'h0000_0060), 0, 0, 0, 0, 0);
    step(mk(5'd1, 5'd9, 5'd7, 1'b0, 32'h0000_0070), 0, 0, 0, 0, 0);
    step(lw8, 0, 0, 0, 0, 0);
    step(use8, 1, 0, 1, 0, 0);
    step(lw8, 0, 0, 0, 0, 0);
    step(use8, 1, 1, 0, 0, 0);
    step(use8, 1, 1, 0, 0, 0);
    step(use8, 1, 1, 0, 0, 1);
    step(use8, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(lw8, 0, 0, 0, 0, 0);
      step(use8, 1, 0, 0, 0, 0);
      step(use8, 1, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    chk("lu_count_after_5", 128'(load_use_count), 128'(5));
    chk("sat_lu_count_after_5", 128'(s_load_use_count), 128'(3));

    cur = '0;
    u = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (last_ifw) begin
        cur = stage_t'({$urandom, $urandom, $urandom, $urandom});
        cur.rs = 5'($urandom_range(0, 3));
        cur.rt = 5'($urandom_range(0, 3));
        cur.mr = ($urandom_range(0, 1) == 1);
        u = ($urandom_range(0, 1) == 1);
      end
      step(cur, u, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 99) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("reg_queue_drained", 128'(q_reg.size()), 128'(0));
    chk("comb_queue_drained", 128'(q_comb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
